hpfp_mul_round: RTL and testbench

- Downstream stage of the half-precision (HPFP) multiplier. Consumes the 22-bit significand product from the 11x11 Wallace-tree multiplier, together with the operand exponents, sign and special-case flags.
- Normalizes, rounds to nearest-even, checks exponent range and packs an IEEE-754 binary16 result.
- Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/hpfp_mul_round.sv | 145 ++++++++++++++
 tb/tb_hpfp_mul_round.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hpfp_mul_round.sv
// binary16 multiplier back end: normalize, round-to-nearest-even, range check, pack.
// Optional exception flag output is enabled by defining HPFP_MUL_FLAGS_EN.
module hpfp_mul_round #(
  parameter int unsigned BIAS  = 15,
  parameter int unsigned EXP_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp_a,
  input  logic [EXP_W-1:0] in_exp_b,
  input  logic [21:0]      in_prod,
  input  logic             in_zero,
  input  logic             in_inf,
  input  logic             in_nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result
`ifdef HPFP_MUL_FLAGS_EN
  ,
  output logic [3:0]       out_flags
`endif
);

  // Two extra bits give a signed exponent wide enough for sum, normalize and round carry.
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned MW = 10;

  logic          s2_load;
  logic          s1_adv;
  logic          s1_valid;
  logic          s1_sign;
  logic [EW-1:0] s1_e;
  logic [MW-1:0] s1_mant;
  logic          s1_guard;
  logic          s1_sticky;
  logic          s1_zero;
  logic          s1_inf;
  logic          s1_nan;

  logic [EW-1:0] n1_e;
  logic [MW-1:0] n1_mant;
  logic          n1_guard;
  logic          n1_sticky;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_load;
  assign in_ready = s1_adv;

  // Normalize the product so the hidden bit is dropped and guard/sticky are split out.
  always_comb begin
    n1_e      = EW'(in_exp_a) + EW'(in_exp_b) - EW'(BIAS);
    n1_mant   = in_prod[19:10];
    n1_guard  = in_prod[9];
    n1_sticky = |in_prod[8:0];
    if (in_prod[21]) begin
      n1_e      = n1_e + EW'(1);
      n1_mant   = in_prod[20:11];
      n1_guard  = in_prod[10];
      n1_sticky = |in_prod[9:0];
    end
  end

  logic          round_up;
  logic          carry;
  logic [MW-1:0] mant_r;
  logic [EW-1:0] e_r;
  logic          ovf;
  logic          unf;
  logic          is_nan;
  logic [15:0]   n2_result;

  assign round_up        = s1_guard & (s1_sticky | s1_mant[0]);
  assign {carry, mant_r} = {1'b0, s1_mant} + (MW+1)'(round_up);
  assign e_r             = s1_e + EW'(carry);
  assign ovf             = !e_r[EW-1] && (e_r >= EW'(31));
  assign unf             = e_r[EW-1] || (e_r == '0);
  assign is_nan          = s1_nan | (s1_inf & s1_zero);

  // Special operands take precedence over range checks.
  always_comb begin
    n2_result = {s1_sign, e_r[EXP_W-1:0], mant_r};
    if (is_nan)       n2_result = 16'h7E00;
    else if (s1_inf)  n2_result = {s1_sign, 5'h1F, 10'h000};
    else if (s1_zero) n2_result = {s1_sign, 15'h0000};
    else if (ovf)     n2_result = {s1_sign, 5'h1F, 10'h000};
    else if (unf)     n2_result = {s1_sign, 15'h0000};
  end

`ifdef HPFP_MUL_FLAGS_EN
  logic       is_spec;
  logic [3:0] n2_flags;

  assign is_spec  = is_nan | s1_inf | s1_zero;
  assign n2_flags = {is_nan,
                     !is_spec & ovf,
                     !is_spec & !ovf & unf,
                     !is_spec & (ovf | unf | s1_guard | s1_sticky)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_e       <= '0;
      s1_mant    <= '0;
      s1_guard   <= 1'b0;
      s1_sticky  <= 1'b0;
      s1_zero    <= 1'b0;
      s1_inf     <= 1'b0;
      s1_nan     <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
`ifdef HPFP_MUL_FLAGS_EN
      out_flags  <= 4'h0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign   <= in_sign;
          s1_e      <= n1_e;
          s1_mant   <= n1_mant;
          s1_guard  <= n1_guard;
          s1_sticky <= n1_sticky;
          s1_zero   <= in_zero;
          s1_inf    <= in_inf;
          s1_nan    <= in_nan;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= n2_result;
`ifdef HPFP_MUL_FLAGS_EN
          out_flags  <= n2_flags;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_hpfp_mul_round.sv
// Bench for hpfp_mul_round: directed corner cases, backpressure, reset, random traffic vs arithmetic model.
module tb_hpfp_mul_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp_a;
  logic [4:0]  in_exp_b;
  logic [21:0] in_prod;
  logic        in_zero;
  logic        in_inf;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
`ifdef HPFP_MUL_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  hpfp_mul_round #(.BIAS(15), .EXP_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
    .in_prod(in_prod), .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
`ifdef HPFP_MUL_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pops = 0;
  logic acc;
  logic rdy;
  logic [19:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact-value model: integer quotient/remainder rounding, then IEEE special handling.
  function automatic logic [19:0] model(input logic s, input logic [4:0] ea, input logic [4:0] eb,
                                        input logic [21:0] p, input logic z, input logic i,
                                        input logic n);
    int e;
    int sh;
    int unsigned pv, q, rem, half;
    logic [3:0] f;
    logic [15:0] r;
    e  = int'(ea) + int'(eb) - 15;
    pv = int'(p);
    if (pv >= 32'h200000) begin sh = 11; e = e + 1; end
    else sh = 10;
    q    = pv >> sh;
    rem  = pv & ((32'd1 << sh) - 1);
    half = 32'd1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == 2048) begin q = 1024; e = e + 1; end
    f = 4'b0000;
    if (n || (i && z))   begin r = 16'h7E00; f = 4'b1000; end
    else if (i)          r = {s, 15'h7C00};
    else if (z)          r = {s, 15'h0000};
    else if (e >= 31)    begin r = {s, 15'h7C00}; f = 4'b0101; end
    else if (e <= 0)     begin r = {s, 15'h0000}; f = 4'b0011; end
    else begin
      r = {s, 5'(e), 10'(q - 1024)};
      f = {3'b000, rem != 0};
    end
    return {f, r};
  endfunction

  // One clock: sample handshakes mid-low-phase, update scoreboard, advance to next negedge.
  task automatic step();
    logic [19:0] e;
    #1;
    rdy = in_ready;
    acc = in_valid && in_ready;
    if (acc) sb.push_back(model(in_sign, in_exp_a, in_exp_b, in_prod, in_zero, in_inf, in_nan));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_out", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_result", 32'(out_result), 32'(e[15:0]));
`ifdef HPFP_MUL_FLAGS_EN
        chk("sb_flags", 32'(out_flags), 32'(e[19:16]));
`endif
        pops++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic s, input logic [4:0] ea, input logic [4:0] eb,
                        input logic [21:0] p, input logic z, input logic i, input logic n);
    in_sign = s; in_exp_a = ea; in_exp_b = eb; in_prod = p;
    in_zero = z; in_inf = i; in_nan = n;
  endtask

  task automatic directed(input string tag, input logic s, input logic [4:0] ea,
                          input logic [4:0] eb, input logic [21:0] p, input logic z,
                          input logic i, input logic n, input logic [15:0] er,
                          input logic [3:0] ef);
    set_in(s, ea, eb, p, z, i, n);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'(out_result), 32'(er));
`ifdef HPFP_MUL_FLAGS_EN
    chk({tag, "_flags"}, 32'(out_flags), 32'(ef));
`else
    if (ef === 4'hx) chk({tag, "_flagarg"}, 32'd0, 32'd1);
`endif
    step();
  endtask

  function automatic logic [21:0] rand_prod();
    logic [10:0] a, b;
    a = {1'b1, 10'($urandom_range(0, 1023))};
    b = {1'b1, 10'($urandom_range(0, 1023))};
    return 22'(a) * 22'(b);
  endfunction

  logic [15:0] held;
  int pops0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 22'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef HPFP_MUL_FLAGS_EN
    chk("rst_flags", 32'(out_flags), 32'h0);
`endif

    directed("one",     1'b0, 5'd15, 5'd15, 22'h100000, 1'b0, 1'b0, 1'b0, 16'h3C00, 4'b0000);
    directed("onep5sq", 1'b0, 5'd15, 5'd15, 22'h240000, 1'b0, 1'b0, 1'b0, 16'h4080, 4'b0000);
    directed("tie_even",1'b0, 5'd15, 5'd15, 22'h100200, 1'b0, 1'b0, 1'b0, 16'h3C00, 4'b0001);
    directed("tie_odd", 1'b0, 5'd15, 5'd15, 22'h100600, 1'b0, 1'b0, 1'b0, 16'h3C02, 4'b0001);
    directed("rnd_carry",1'b0,5'd15, 5'd15, 22'h1FFE00, 1'b0, 1'b0, 1'b0, 16'h4000, 4'b0001);
    directed("ovf",     1'b0, 5'd30, 5'd30, 22'h100000, 1'b0, 1'b0, 1'b0, 16'h7C00, 4'b0101);
    directed("unf",     1'b1, 5'd1,  5'd1,  22'h100000, 1'b0, 1'b0, 1'b0, 16'h8000, 4'b0011);
    directed("inf_zero",1'b0, 5'd31, 5'd0,  22'h100000, 1'b1, 1'b1, 1'b0, 16'h7E00, 4'b1000);
    directed("neg_inf", 1'b1, 5'd31, 5'd15, 22'h100000, 1'b0, 1'b1, 1'b0, 16'hFC00, 4'b0000);
    directed("nan",     1'b0, 5'd31, 5'd15, 22'h180000, 1'b0, 1'b0, 1'b1, 16'h7E00, 4'b1000);
    directed("zero",    1'b1, 5'd0,  5'd15, 22'h100000, 1'b1, 1'b0, 1'b0, 16'h8000, 4'b0000);

    // Backpressure: three back-to-back beats against a stalled sink.
    pops0 = pops;
    out_ready = 1'b0; in_valid = 1'b1;
    set_in(1'b0, 5'd15, 5'd16, rand_prod(), 1'b0, 1'b0, 1'b0);
    step(); chk("bp_acc_a", 32'(acc), 32'd1);
    set_in(1'b1, 5'd14, 5'd15, rand_prod(), 1'b0, 1'b0, 1'b0);
    step(); chk("bp_acc_b", 32'(acc), 32'd1);
    set_in(1'b0, 5'd16, 5'd16, rand_prod(), 1'b0, 1'b0, 1'b0);
    held = out_result;
    step(); chk("bp_in_ready_low", 32'(rdy), 32'd0);
    chk("bp_hold1", 32'(out_result), 32'(held));
    step(); chk("bp_hold2", 32'(out_result), 32'(held));
    chk("bp_valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) step();
    chk("bp_acc_c", 32'(acc), 32'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    chk("bp_all_out", 32'(pops - pops0), 32'd3);

    // Reset with both stages occupied.
    out_ready = 1'b0; in_valid = 1'b1;
    set_in(1'b0, 5'd15, 5'd15, rand_prod(), 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("rst_full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_result", 32'(out_result), 32'h0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);

    // Random traffic with random valid/ready and occasional special operands.
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             rand_prod(), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 23) == 0));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
